// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// uart_tx_engine: UART transmitter with TX FIFO, baud divider and frame FSM.
// Revision: 1.0
// ============================================================================
module uart_tx_engine #(
  parameter int MAX_DATA_BITS = 9,
  parameter int DIV_W         = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MAX_DATA_BITS-1:0] tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_two_stop,
  input  logic [DIV_W-1:0]         cfg_baud_div,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic [CNT_W-1:0]         fifo_count
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [3:0]       MIN_N    = 4'd5;
  localparam logic [3:0]       MAX_N    = 4'(MAX_DATA_BITS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [MAX_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     push, pop;

  state_t                   state_q, state_d;
  logic [MAX_DATA_BITS-1:0] word_q, word_d;
  logic [3:0]               nbits_q, nbits_d, idx_q, idx_d;
  logic                     par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic                     two_stop_q, two_stop_d, stop2_q, stop2_d;
  logic [DIV_W-1:0]         div_q, div_d, cnt_q, cnt_d;
  logic                     tx_out_q, tx_out_d, busy_q, busy_d, done_q, done_d;

  logic [3:0]               n_clamped;
  logic [MAX_DATA_BITS-1:0] data_mask, next_shift;
  logic [DIV_W-1:0]         div_eff;
  logic                     bit_end, last_stop;

  assign tx_ready   = (count_q != FULL_CNT);
  assign fifo_count = count_q;
  assign tx_out     = tx_out_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;

  assign push      = tx_valid && tx_ready;
  assign bit_end   = (cnt_q == '0);
  assign last_stop = !two_stop_q || stop2_q;
  // A frame is loaded either from IDLE or straight out of the final stop bit.
  assign pop       = (count_q != '0) &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_end && last_stop));

  always_comb begin
    if (cfg_data_bits < MIN_N)      n_clamped = MIN_N;
    else if (cfg_data_bits > MAX_N) n_clamped = MAX_N;
    else                            n_clamped = cfg_data_bits;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      data_mask[i] = (4'(i) < n_clamped);
    end
    div_eff    = (cfg_baud_div == '0) ? DIV_W'(1) : cfg_baud_div;
    next_shift = word_q >> (idx_q + 4'd1);
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    nbits_d    = nbits_q;
    idx_d      = idx_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    div_d      = div_q;
    cnt_d      = bit_end ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
    tx_out_d   = tx_out_q;

    case (state_q)
      IDLE: begin
        cnt_d    = cnt_q;
        tx_out_d = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          idx_d    = 4'd0;
          tx_out_d = word_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == nbits_q - 4'd1) begin
            if (par_en_q) begin
              state_d  = PARITY;
              tx_out_d = (^word_q) ^ par_odd_q;
            end else begin
              state_d  = STOP;
              stop2_d  = 1'b0;
              tx_out_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 4'd1;
            tx_out_d = next_shift[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          stop2_d  = 1'b0;
          tx_out_d = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!last_stop) begin
            stop2_d = 1'b1;
          end else begin
            state_d  = IDLE;
            tx_out_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
      end
    endcase

    // Word bits above N are masked off so parity is a plain reduction.
    if (pop) begin
      state_d    = START;
      word_d     = mem_q[rd_ptr_q] & data_mask;
      nbits_d    = n_clamped;
      idx_d      = 4'd0;
      par_en_d   = cfg_parity_en;
      par_odd_d  = cfg_parity_odd;
      two_stop_d = cfg_two_stop;
      stop2_d    = 1'b0;
      div_d      = div_eff;
      cnt_d      = div_eff - DIV_W'(1);
      tx_out_d   = 1'b0;
    end

    busy_d   = (state_d != IDLE);
    done_d   = (state_d == STOP) && (cnt_d == '0) && (!two_stop_d || stop2_d);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      nbits_q    <= MIN_N;
      idx_q      <= 4'd0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      div_q      <= DIV_W'(1);
      cnt_q      <= '0;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      nbits_q    <= nbits_d;
      idx_q      <= idx_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// tb_uart_tx_engine: randomized scoreboard bench; frames are rebuilt from the
// serial framing rules and compared cycle-by-cycle against tx_out / tx_done.
module tb_uart_tx_engine;

  localparam int MAXB  = 9;
  localparam int DIV_W = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [MAXB-1:0]  tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [3:0]       cfg_data_bits = 4'd8;
  logic             cfg_parity_en = 1'b0;
  logic             cfg_parity_odd = 1'b0;
  logic             cfg_two_stop = 1'b0;
  logic [DIV_W-1:0] cfg_baud_div = 16'd1;
  logic             tx_out, tx_busy, tx_done;
  logic [CNT_W-1:0] fifo_count;

  uart_tx_engine #(.MAX_DATA_BITS(MAXB), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
    .cfg_baud_div(cfg_baud_div), .tx_out(tx_out), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MAXB-1:0] word;
    int              n;
    bit              pen;
    bit              podd;
    int              s;
    int              d;
    bit              b2b;
  } frame_t;

  frame_t sb[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected frame parameters from the configuration currently on the cfg_* pins.
  function automatic frame_t mk(input logic [MAXB-1:0] w, input bit b2b);
    frame_t f;
    int nb = int'(cfg_data_bits);
    f.word = w;
    f.n    = (nb < 5) ? 5 : ((nb > MAXB) ? MAXB : nb);
    f.pen  = cfg_parity_en;
    f.podd = cfg_parity_odd;
    f.s    = cfg_two_stop ? 2 : 1;
    f.d    = (cfg_baud_div == 0) ? 1 : int'(cfg_baud_div);
    f.b2b  = b2b;
    return f;
  endfunction

  function automatic int build(input frame_t f, output logic [511:0] wv);
    bit bits[$];
    bit par = f.podd;
    int len = 0;
    wv = '0;
    bits.push_back(1'b0);
    for (int i = 0; i < f.n; i++) begin
      bits.push_back(f.word[i]);
      par ^= f.word[i];
    end
    if (f.pen) bits.push_back(par);
    for (int i = 0; i < f.s; i++) bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int j = 0; j < f.d; j++) begin
        wv[len] = bits[k];
        len++;
      end
    end
    return len;
  endfunction

  // Monitor: a low level on an idle line opens the next expected frame.
  initial begin : monitor
    frame_t       f;
    logic [511:0] ew, aw, ed, ad;
    int           len = 0;
    int           pos = 0;
    int           last_end = -100;
    bit           inf = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !mon_en) begin
        inf = 1'b0;
      end else begin
        if (!inf && tx_out == 1'b0) begin
          chk("frame_expected", longint'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            f   = sb.pop_front();
            len = build(f, ew);
            ed  = '0;
            ed[len-1] = 1'b1;
            aw  = '0;
            ad  = '0;
            pos = 0;
            inf = 1'b1;
            if (f.b2b) chk("b2b_gap", cyc - last_end, 1);
          end
        end
        if (inf) begin
          aw[pos] = tx_out;
          ad[pos] = tx_done;
          pos++;
          if (pos == len) begin
            inf      = 1'b0;
            last_end = cyc;
            checks++;
            if (aw !== ew) begin
              errors++;
              $display("FAIL frame_wave word=%h: got %h expected %h", f.word, aw, ew);
            end
            checks++;
            if (ad !== ed) begin
              errors++;
              $display("FAIL frame_done word=%h: got %h expected %h", f.word, ad, ed);
            end
          end
        end
      end
    end
  end

  task automatic set_cfg(input int nb, input bit pe, input bit po, input bit ts, input int d);
    cfg_data_bits  = 4'(nb);
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_two_stop   = ts;
    cfg_baud_div   = DIV_W'(d);
  endtask

  // Issues consecutive pushes, one per clock, starting at a falling edge.
  task automatic push_burst(input int n);
    for (int i = 0; i < n; i++) begin
      tx_data  = MAXB'($urandom);
      tx_valid = 1'b1;
      sb.push_back(mk(tx_data, i > 0));
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while ((tx_busy || fifo_count != 0 || sb.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("idle_within_bound", longint'(k < bound), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    repeat (3) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_tx_ready", tx_ready, 1);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // 0x055, 8N1, D=4 with direct latency checks
    set_cfg(8, 0, 0, 0, 4);
    tx_data  = 9'h055;
    tx_valid = 1'b1;
    sb.push_back(mk(tx_data, 1'b0));
    @(posedge clk);
    #1;
    chk("lat_count_after_push", fifo_count, 1);
    chk("lat_line_idle", tx_out, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_start_bit", tx_out, 0);
    chk("lat_busy", tx_busy, 1);
    chk("lat_popped", fifo_count, 0);
    k = 0;
    while (!tx_done && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t1_done_cycle", k, 39);
    @(posedge clk);
    #1;
    chk("t1_busy_falls", tx_busy, 0);
    wait_idle(200);

    // 0x41, 7 bits, odd then even parity, two stop bits, D=2
    set_cfg(7, 1, 1, 1, 2);
    sb.push_back(mk(9'h041, 1'b0));
    tx_data = 9'h041; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(200);
    set_cfg(7, 1, 0, 1, 2);
    sb.push_back(mk(9'h041, 1'b0));
    tx_data = 9'h041; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(200);

    // FIFO fill: five pushes, first one already in flight
    set_cfg(8, 0, 0, 0, 3);
    push_burst(5);
    chk("full_count", fifo_count, 4);
    chk("full_not_ready", tx_ready, 0);
    tx_data  = MAXB'($urandom);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("full_drop_count", fifo_count, 4);
    wait_idle(2000);

    // Clamping of data bits and divisor
    set_cfg(3, 0, 0, 0, 2);
    push_burst(1);
    wait_idle(200);
    set_cfg(15, 1, 0, 0, 2);
    push_burst(1);
    wait_idle(200);
    set_cfg(8, 1, 1, 0, 0);
    push_burst(1);
    wait_idle(200);

    // Randomized configurations
    for (int it = 0; it < 12; it++) begin
      set_cfg($urandom_range(15), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(5));
      push_burst($urandom_range(3, 1));
      wait_idle(1000);
    end

    // Mid-frame configuration change
    set_cfg(8, 0, 0, 0, 3);
    push_burst(1);
    repeat (8) @(negedge clk);
    set_cfg(6, 1, 0, 0, 2);
    tx_data  = MAXB'($urandom);
    tx_valid = 1'b1;
    sb.push_back(mk(tx_data, 1'b1));
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle(500);

    // Reset during DATA with two words queued
    set_cfg(8, 0, 0, 0, 4);
    push_burst(3);
    repeat (8) @(negedge clk);
    chk("pre_rst_count", fifo_count, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx_out", tx_out, 1);
    chk("abort_count", fifo_count, 0);
    chk("abort_busy", tx_busy, 0);
    rst = 1'b0;
    sb.delete();
    repeat (300) @(negedge clk);
    chk("post_abort_idle", tx_busy, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
